// File: rtl/parser_pkg.sv
// parser_pkg: types and constants shared by the parser scheduler slice.
// Holds the FSM state enum, the config FIFO entry struct and NO_HEADER.
package parser_pkg;

  localparam int DATA_W = 32;
  localparam int BYTE_W = 8;
  localparam int HDR_MAX_LEN = 16;
  localparam int NUM_HEADERS_DEF = 2;
  localparam int NEXT_TABLE_SIZE_DEF = 2;

  localparam logic [DATA_W-1:0] NO_HEADER = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_CFG,
    S_ISSUE_PKT,
    S_WAIT,
    S_HALT
  } sched_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] hdr_id;
    logic [DATA_W-1:0] hdr_len;
    logic [DATA_W-1:0] tag_start;
    logic [DATA_W-1:0] tag_len;
    logic [NEXT_TABLE_SIZE_DEF-1:0][DATA_W-1:0] next_table;
  } cfg_entry_t;

endpackage

// File: rtl/parser_sched_if.sv
// parser_sched_if: upstream packet/config, parser and result signals.
// slave = scheduler side, master = environment (upstream + parser).
interface parser_sched_if
  import parser_pkg::*;
#(
  parameter int NUM_HEADERS = NUM_HEADERS_DEF,
  parameter int NEXT_TABLE_SIZE = NEXT_TABLE_SIZE_DEF
);
  logic                                     pkt_valid_i;
  logic [HDR_MAX_LEN-1:0][BYTE_W-1:0]       pkt_hdr_i;
  logic                                     pkt_ready_o;
  logic                                     cfg_valid_i;
  logic [DATA_W-1:0]                        cfg_hdr_id_i;
  logic [DATA_W-1:0]                        cfg_hdr_len_i;
  logic [DATA_W-1:0]                        cfg_next_tag_start_i;
  logic [DATA_W-1:0]                        cfg_next_tag_len_i;
  logic [NEXT_TABLE_SIZE-1:0][DATA_W-1:0]   cfg_next_table_i;
  logic                                     cfg_ready_o;
  logic                                     psr_start_o;
  logic [HDR_MAX_LEN-1:0][BYTE_W-1:0]       psr_hdr_o;
  logic                                     psr_mod_start_o;
  logic [DATA_W-1:0]                        psr_mod_hdr_id_o;
  logic [DATA_W-1:0]                        psr_mod_hdr_len_o;
  logic [DATA_W-1:0]                        psr_mod_next_tag_start_o;
  logic [DATA_W-1:0]                        psr_mod_next_tag_len_o;
  logic [NEXT_TABLE_SIZE-1:0][DATA_W-1:0]   psr_mod_next_table_o;
  logic                                     psr_ready_i;
  logic [NUM_HEADERS-1:0][DATA_W-1:0]       psr_hdrs_i;
  logic                                     res_valid_o;
  logic [NUM_HEADERS-1:0][DATA_W-1:0]       res_hdrs_o;
  logic                                     stuck_o;

  modport slave (
    input  pkt_valid_i, pkt_hdr_i,
    output pkt_ready_o,
    input  cfg_valid_i, cfg_hdr_id_i, cfg_hdr_len_i,
    input  cfg_next_tag_start_i, cfg_next_tag_len_i, cfg_next_table_i,
    output cfg_ready_o,
    output psr_start_o, psr_hdr_o,
    output psr_mod_start_o, psr_mod_hdr_id_o, psr_mod_hdr_len_o,
    output psr_mod_next_tag_start_o, psr_mod_next_tag_len_o,
    output psr_mod_next_table_o,
    input  psr_ready_i, psr_hdrs_i,
    output res_valid_o, res_hdrs_o, stuck_o
  );

  modport master (
    output pkt_valid_i, pkt_hdr_i,
    input  pkt_ready_o,
    output cfg_valid_i, cfg_hdr_id_i, cfg_hdr_len_i,
    output cfg_next_tag_start_i, cfg_next_tag_len_i, cfg_next_table_i,
    input  cfg_ready_o,
    input  psr_start_o, psr_hdr_o,
    input  psr_mod_start_o, psr_mod_hdr_id_o, psr_mod_hdr_len_o,
    input  psr_mod_next_tag_start_o, psr_mod_next_tag_len_o,
    input  psr_mod_next_table_o,
    output psr_ready_i, psr_hdrs_i,
    input  res_valid_o, res_hdrs_o, stuck_o
  );
endinterface

// File: rtl/sched_fifo.sv
// sched_fifo: synchronous FIFO of cfg_entry_t with full/empty flags.
// Ports: clk, rst (sync, high), i_push/i_data, i_pop/o_data, o_full, o_empty.
module sched_fifo
  import parser_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  cfg_entry_t i_data,
  input  logic       i_pop,
  output cfg_entry_t o_data,
  output logic       o_full,
  output logic       o_empty
);
  localparam int AW = $clog2(DEPTH);

  cfg_entry_t      r_mem [DEPTH];
  logic [AW:0]     r_wp;
  logic [AW:0]     r_rp;
  logic            w_push;
  logic            w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_empty = (r_wp == r_rp);
  // extra pointer bit tells a full wrap from empty
  assign o_full  = (r_wp[AW] != r_rp[AW]) &&
                   (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_data  = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/parser_sched.sv
// parser_sched: serializes config writes and packet starts to the parser.
// Ports: clk, rst (sync, high), bus (parser_sched_if.slave). Optional
// watchdog/HALT state enabled by macro PARSER_SCHED_WATCHDOG_EN.
module parser_sched
  import parser_pkg::*;
#(
  parameter int NUM_HEADERS     = NUM_HEADERS_DEF,
  parameter int NEXT_TABLE_SIZE = NEXT_TABLE_SIZE_DEF,
  parameter int CFG_FIFO_DEPTH  = 4,
  parameter int MAX_CFG_BURST   = 2,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input logic           clk,
  input logic           rst,
  parser_sched_if.slave bus
);
  localparam int BW = $clog2(MAX_CFG_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_CFG_BURST);

  sched_state_t r_state;
  sched_state_t w_next;

  logic                               r_buf_valid;
  logic [HDR_MAX_LEN-1:0][BYTE_W-1:0] r_buf_hdr;
  logic [BW-1:0]                      r_burst;
  logic [BW-1:0]                      w_burst_nxt;
  cfg_entry_t                         r_cfg_cur;
  logic                               r_res_valid;
  logic [NUM_HEADERS-1:0][DATA_W-1:0] r_res_hdrs;

  logic [NEXT_TABLE_SIZE-1:0][DATA_W-1:0] w_tbl;
  cfg_entry_t w_cfg_in;
  cfg_entry_t w_cfg_head;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_pkt_acc;
  logic       w_start;
  logic       w_mod;
  logic       w_done;
  logic       w_halt;

`ifdef PARSER_SCHED_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
  logic [WW-1:0] r_wd;

  assign w_halt = (r_state == S_HALT);

  always_ff @(posedge clk) begin
    if (rst) r_wd <= '0;
    else if (r_state == S_WAIT) r_wd <= r_wd + 1'b1;
    else r_wd <= '0;
  end
`else
  assign w_halt = 1'b0;
`endif

  assign w_tbl    = bus.cfg_next_table_i;
  assign w_cfg_in = '{
    hdr_id:     bus.cfg_hdr_id_i,
    hdr_len:    bus.cfg_hdr_len_i,
    tag_start:  bus.cfg_next_tag_start_i,
    tag_len:    bus.cfg_next_tag_len_i,
    next_table: w_tbl
  };

  assign bus.pkt_ready_o = !r_buf_valid && !w_halt;
  assign bus.cfg_ready_o = !w_full && !w_halt;
  assign w_pkt_acc = bus.pkt_valid_i && bus.pkt_ready_o;
  assign w_push    = bus.cfg_valid_i && bus.cfg_ready_o;

  sched_fifo #(.DEPTH(CFG_FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_cfg_in),
    .i_pop   (w_pop),
    .o_data  (w_cfg_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_next      = r_state;
    w_burst_nxt = r_burst;
    w_pop       = 1'b0;
    w_start     = 1'b0;
    w_mod       = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // configs only count against the burst while a packet waits
        if (!w_empty && (!r_buf_valid || r_burst < BURST_MAX)) begin
          w_next      = S_ISSUE_CFG;
          w_pop       = 1'b1;
          w_burst_nxt = r_buf_valid ? r_burst + 1'b1 : '0;
        end else if (r_buf_valid) begin
          w_next      = S_ISSUE_PKT;
          w_burst_nxt = '0;
        end else begin
          w_burst_nxt = '0;
        end
      end
      S_ISSUE_CFG: begin
        w_mod  = 1'b1;
        w_next = S_IDLE;
      end
      S_ISSUE_PKT: begin
        w_start = 1'b1;
        w_next  = S_WAIT;
      end
      S_WAIT: begin
        if (bus.psr_ready_i) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end
`ifdef PARSER_SCHED_WATCHDOG_EN
        else if (r_wd == WD_LAST) begin
          w_next = S_HALT;
        end
`endif
      end
`ifdef PARSER_SCHED_WATCHDOG_EN
      S_HALT: w_next = S_HALT;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_burst     <= '0;
      r_buf_valid <= 1'b0;
      r_buf_hdr   <= '0;
      r_cfg_cur   <= '0;
      r_res_valid <= 1'b0;
      r_res_hdrs  <= {NUM_HEADERS{NO_HEADER}};
    end else begin
      r_state     <= w_next;
      r_burst     <= w_burst_nxt;
      r_res_valid <= w_done;
      if (w_pop) r_cfg_cur <= w_cfg_head;
      if (w_pkt_acc) begin
        r_buf_valid <= 1'b1;
        r_buf_hdr   <= bus.pkt_hdr_i;
      end else if (w_done) begin
        r_buf_valid <= 1'b0;
      end
      if (w_done) r_res_hdrs <= bus.psr_hdrs_i;
    end
  end

  assign bus.psr_start_o              = w_start;
  assign bus.psr_hdr_o                = r_buf_hdr;
  assign bus.psr_mod_start_o          = w_mod;
  assign bus.psr_mod_hdr_id_o         = r_cfg_cur.hdr_id;
  assign bus.psr_mod_hdr_len_o        = r_cfg_cur.hdr_len;
  assign bus.psr_mod_next_tag_start_o = r_cfg_cur.tag_start;
  assign bus.psr_mod_next_tag_len_o   = r_cfg_cur.tag_len;
  assign bus.psr_mod_next_table_o     = r_cfg_cur.next_table;
  assign bus.res_valid_o              = r_res_valid;
  assign bus.res_hdrs_o               = r_res_hdrs;
  assign bus.stuck_o                  = w_halt;
endmodule

// File: tb/tb_parser_sched.sv
// tb_parser_sched: scoreboard bench for parser_sched with a stub parser.
// Expected issue/result events are queued by stimulus, popped by a monitor.
module tb_parser_sched;
  import parser_pkg::*;

  localparam int EV_CFG = 0;
  localparam int EV_PKT = 1;
  localparam int EV_RES = 2;

  typedef struct {
    int          kind;
    logic [63:0] data;
  } ev_t;

  typedef logic [HDR_MAX_LEN-1:0][BYTE_W-1:0] hdr_t;

  logic clk = 1'b0;
  logic rst;
  logic hang;
  int   vectors = 0;
  int   errors  = 0;
  ev_t  q[$];
  time  last_cfg_t = 0;
  time  last_pkt_t = 0;

  always #5 clk = ~clk;

  parser_sched_if #(.NUM_HEADERS(2), .NEXT_TABLE_SIZE(2)) bus ();

  parser_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // stub parser: ready drops at start, rises after a few cycles unless hung
  logic                  p_busy;
  logic [2:0]            p_cnt;
  logic [31:0]           p_len;
  logic [1:0][31:0]      p_tbl;
  logic [15:0]           p_et;

  always @(posedge clk) begin
    if (rst) begin
      bus.psr_ready_i <= 1'b1;
      bus.psr_hdrs_i  <= '0;
      p_busy <= 1'b0;
      p_cnt  <= '0;
      p_len  <= '0;
      p_tbl  <= '0;
      p_et   <= '0;
    end else begin
      if (bus.psr_mod_start_o) begin
        p_len <= bus.psr_mod_hdr_len_o;
        p_tbl <= bus.psr_mod_next_table_o;
      end
      if (bus.psr_start_o) begin
        bus.psr_ready_i <= 1'b0;
        p_busy <= 1'b1;
        p_cnt  <= 3'd3;
        p_et   <= {bus.psr_hdr_o[12], bus.psr_hdr_o[13]};
      end else if (p_busy && !hang) begin
        if (p_cnt == 0) begin
          bus.psr_ready_i   <= 1'b1;
          p_busy            <= 1'b0;
          bus.psr_hdrs_i[0] <= '0;
          bus.psr_hdrs_i[1] <=
            (p_et == p_tbl[0][31:16] || p_et == p_tbl[1][31:16]) ?
            p_len : NO_HEADER;
        end else begin
          p_cnt <= p_cnt - 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [63:0] data);
    ev_t e;
    vectors++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d data %0h, expected none",
               kind, data);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.data !== data) begin
        errors++;
        $display("FAIL event_order: got kind %0d data %0h expected kind %0d data %0h",
                 kind, data, e.kind, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.psr_start_o || bus.psr_mod_start_o)
        chk("exclusive", {63'd0, bus.psr_start_o && bus.psr_mod_start_o}, 64'd0);
      if (bus.psr_mod_start_o) begin
        last_cfg_t = $time;
        expect_ev(EV_CFG, {32'd0, bus.psr_mod_hdr_id_o});
      end
      if (bus.psr_start_o) begin
        last_pkt_t = $time;
        expect_ev(EV_PKT, {56'd0, bus.psr_hdr_o[0]});
      end
      if (bus.res_valid_o)
        expect_ev(EV_RES, {bus.res_hdrs_o[1], bus.res_hdrs_o[0]});
    end
  end

  function automatic hdr_t mk_hdr(input logic [7:0] tag, input logic [15:0] et);
    hdr_t h;
    h = '0;
    h[0]  = tag;
    h[12] = et[15:8];
    h[13] = et[7:0];
    return h;
  endfunction

  function automatic void exp_ev(input int kind, input logic [63:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    q.push_back(e);
  endfunction

  task automatic push_cfg(input logic [31:0] id, input logic [31:0] len,
                          input logic [31:0] t0, input logic [31:0] t1,
                          output time t_acc);
    logic r;
    logic ok;
    ok = 1'b0;
    t_acc = 0;
    bus.cfg_valid_i          = 1'b1;
    bus.cfg_hdr_id_i         = id;
    bus.cfg_hdr_len_i        = len;
    bus.cfg_next_tag_start_i = 32'd12;
    bus.cfg_next_tag_len_i   = 32'd16;
    bus.cfg_next_table_i[0]  = t0;
    bus.cfg_next_table_i[1]  = t1;
    for (int i = 0; i < 300; i++) begin
      r = bus.cfg_ready_o;
      @(posedge clk);
      if (r) begin
        ok = 1'b1;
        t_acc = $time;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.cfg_valid_i = 1'b0;
    if (!ok) chk("cfg_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_pkt(input hdr_t h, output time t_acc);
    logic r;
    logic ok;
    ok = 1'b0;
    t_acc = 0;
    bus.pkt_valid_i = 1'b1;
    bus.pkt_hdr_i   = h;
    for (int i = 0; i < 300; i++) begin
      r = bus.pkt_ready_o;
      @(posedge clk);
      if (r) begin
        ok = 1'b1;
        t_acc = $time;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.pkt_valid_i = 1'b0;
    if (!ok) chk("pkt_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_drain(input int n);
    for (int i = 0; i < n; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    q.delete();
    rst = 1'b0;
    @(negedge clk);
  endtask

  localparam logic [31:0] T_V4 = 32'h0800_0001;
  localparam logic [31:0] T_V6 = 32'h86DD_0001;

  time t_a;
  time t_b;
  time t_x;
  int  n;

  initial begin
    rst  = 1'b1;
    hang = 1'b0;
    bus.pkt_valid_i          = 1'b0;
    bus.pkt_hdr_i            = '0;
    bus.cfg_valid_i          = 1'b0;
    bus.cfg_hdr_id_i         = '0;
    bus.cfg_hdr_len_i        = '0;
    bus.cfg_next_tag_start_i = '0;
    bus.cfg_next_tag_len_i   = '0;
    bus.cfg_next_table_i     = '0;
    do_reset();

    // reset values
    chk("rst_pkt_ready", {63'd0, bus.pkt_ready_o}, 64'd1);
    chk("rst_cfg_ready", {63'd0, bus.cfg_ready_o}, 64'd1);
    chk("rst_psr_start", {63'd0, bus.psr_start_o}, 64'd0);
    chk("rst_mod_start", {63'd0, bus.psr_mod_start_o}, 64'd0);
    chk("rst_res_valid", {63'd0, bus.res_valid_o}, 64'd0);
    chk("rst_stuck", {63'd0, bus.stuck_o}, 64'd0);
    chk("rst_res_hdrs", {bus.res_hdrs_o[1], bus.res_hdrs_o[0]},
        {NO_HEADER, NO_HEADER});
    chk("rst_psr_hdr", {63'd0, bus.psr_hdr_o == '0}, 64'd1);

    // config then one IPv4 packet
    exp_ev(EV_CFG, 64'd0);
    exp_ev(EV_PKT, 64'h01);
    exp_ev(EV_RES, {32'd14, 32'd0});
    push_cfg(0, 14, T_V4, T_V6, t_a);
    repeat (4) @(negedge clk);
    chk("cfg_latency", 64'(last_cfg_t - t_a), 64'd15);
    send_pkt(mk_hdr(8'h01, 16'h0800), t_b);
    wait_drain(50);
    chk("pkt_latency", 64'(last_pkt_t - t_b), 64'd15);

    // bounded burst: packet and 4 configs arrive together
    exp_ev(EV_CFG, 64'd1);
    exp_ev(EV_CFG, 64'd2);
    exp_ev(EV_PKT, 64'h02);
    exp_ev(EV_RES, {32'd22, 32'd0});
    exp_ev(EV_CFG, 64'd3);
    exp_ev(EV_CFG, 64'd4);
    fork
      send_pkt(mk_hdr(8'h02, 16'h86DD), t_a);
      begin
        push_cfg(1, 21, T_V4, T_V6, t_x);
        push_cfg(2, 22, T_V4, T_V6, t_x);
        push_cfg(3, 23, T_V4, T_V6, t_x);
        push_cfg(4, 24, T_V4, T_V6, t_x);
      end
    join
    wait_drain(80);

    // back-pressure while a parse stalls
    hang = 1'b1;
    exp_ev(EV_PKT, 64'h03);
    send_pkt(mk_hdr(8'h03, 16'h0800), t_a);
    repeat (3) @(negedge clk);
    push_cfg(5, 25, T_V4, T_V6, t_x);
    push_cfg(6, 26, T_V4, T_V6, t_x);
    push_cfg(7, 27, T_V4, T_V6, t_x);
    chk("cfg_ready_3", {63'd0, bus.cfg_ready_o}, 64'd1);
    push_cfg(8, 28, T_V4, T_V6, t_x);
    chk("cfg_full", {63'd0, bus.cfg_ready_o}, 64'd0);
    exp_ev(EV_RES, {32'd24, 32'd0});
    exp_ev(EV_CFG, 64'd5);
    exp_ev(EV_CFG, 64'd6);
    exp_ev(EV_CFG, 64'd7);
    exp_ev(EV_PKT, 64'h04);
    exp_ev(EV_RES, {NO_HEADER, 32'd0});
    exp_ev(EV_CFG, 64'd8);
    exp_ev(EV_CFG, 64'd9);
    fork
      send_pkt(mk_hdr(8'h04, 16'h1234), t_x);
      push_cfg(9, 29, T_V4, T_V6, t_b);
      begin
        repeat (3) @(negedge clk);
        chk("pkt2_held", {63'd0, bus.pkt_ready_o}, 64'd0);
        chk("cfg5_held", {63'd0, bus.cfg_ready_o}, 64'd0);
        chk("no_early_res", 64'(q.size()), 64'd8);
        hang = 1'b0;
      end
    join
    wait_drain(150);

    // hung parser
    hang = 1'b1;
    exp_ev(EV_PKT, 64'h05);
    send_pkt(mk_hdr(8'h05, 16'h0800), t_a);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.psr_start_o) break;
      @(negedge clk);
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (bus.stuck_o) break;
    end
`ifdef PARSER_SCHED_WATCHDOG_EN
    chk("wd_cycles", 64'(n), 64'd65);
    chk("halt_stuck", {63'd0, bus.stuck_o}, 64'd1);
    chk("halt_pkt_ready", {63'd0, bus.pkt_ready_o}, 64'd0);
    chk("halt_cfg_ready", {63'd0, bus.cfg_ready_o}, 64'd0);
    hang = 1'b0;
    repeat (20) @(negedge clk);
    chk("halt_sticky", {63'd0, bus.stuck_o}, 64'd1);
    chk("halt_no_res", {63'd0, bus.res_valid_o}, 64'd0);
    chk("halt_q", 64'(q.size()), 64'd0);
    do_reset();
    chk("halt_rst_clear", {63'd0, bus.stuck_o}, 64'd0);
`else
    chk("nowd_cycles", 64'(n), 64'd100);
    chk("nowd_stuck", {63'd0, bus.stuck_o}, 64'd0);
    chk("nowd_pkt_held", {63'd0, bus.pkt_ready_o}, 64'd0);
    exp_ev(EV_RES, {32'd29, 32'd0});
    hang = 1'b0;
    wait_drain(50);
`endif

    // reset in the middle of a parse
    hang = 1'b1;
    exp_ev(EV_PKT, 64'h06);
    send_pkt(mk_hdr(8'h06, 16'h0800), t_a);
    repeat (5) @(negedge clk);
    chk("pre_rst_q", 64'(q.size()), 64'd0);
    do_reset();
    hang = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_res_hdrs", {bus.res_hdrs_o[1], bus.res_hdrs_o[0]},
        {NO_HEADER, NO_HEADER});
    chk("midrst_pkt_ready", {63'd0, bus.pkt_ready_o}, 64'd1);
    exp_ev(EV_CFG, 64'd0);
    exp_ev(EV_PKT, 64'h07);
    exp_ev(EV_RES, {32'd14, 32'd0});
    push_cfg(0, 14, T_V4, T_V6, t_x);
    repeat (4) @(negedge clk);
    send_pkt(mk_hdr(8'h07, 16'h0800), t_a);
    wait_drain(50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
